mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning bus data width; legal values are 32 and 64; LANES=DATA_W/8.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: cpu_clk_50M  in  1  clock; cpu_rst_n  in  1  async active-low reset.
REQ-004 SHALL have: ex_valid  in  1  access request from execute.
REQ-005 SHALL have: ex_load / ex_store  in  1 each  access type; ex_size  in  2  0=byte 1=half 2=word 3=dword; ex_unsigned  in  1  zero-extend load.
REQ-006 SHALL have: ex_addr  in  ADDR_W  effective address; ex_wdata  in  DATA_W  store data, LSB-aligned.
REQ-007 SHALL have: ex_ready  out  1  unit can accept; flush  in  1  exception flush.
REQ-008 SHALL have: data_req  out  1; data_wr  out  1; data_size  out  2; data_addr  out  ADDR_W.
REQ-009 SHALL have: data_wdata  out  DATA_W; data_wstrb  out  LANES.
REQ-010 SHALL have: data_addr_ok  in  1; data_data_ok  in  1; data_rdata  in  DATA_W.
REQ-011 SHALL have: resp_valid  out  1  completion pulse; resp_rdata  out  DATA_W  formatted load data.
REQ-012 SHALL have: resp_exc  out  2  00 none, 01 ADEL, 10 ADES; badvaddr  out  ADDR_W.
REQ-013 SHALL have: mem_stall  out  1  hold pipeline.

Function
REQ-014 SHALL implement states IDLE, REQ, WAIT_DATA, DRAIN, EXC.
REQ-015 ex_ready SHALL be 1 only in IDLE; acceptance = ex_valid & (ex_load|ex_store) & ex_ready & ~flush; all request fields are latched on acceptance.
REQ-016 Misalignment SHALL be: half addr[0]!=0, word addr[1:0]!=0, dword addr[2:0]!=0, or size 3 when DATA_W=32.
REQ-017 A misaligned accept SHALL go IDLE->EXC with no bus request; EXC->IDLE next cycle with resp_valid=1, resp_exc=ADEL (load) or ADES (store), badvaddr=latched addr.
REQ-018 An aligned accept SHALL go IDLE->REQ; data_req=1 from the next cycle and SHALL be held with stable data_addr, data_wr, data_size, data_wdata and data_wstrb until data_addr_ok is sampled high.
REQ-019 REQ SHALL go to WAIT_DATA on data_addr_ok; WAIT_DATA SHALL go to IDLE on data_data_ok, with resp_valid=1 and resp_exc=00 for exactly one cycle in the following cycle.
REQ-020 data_data_ok in the same cycle as data_addr_ok SHALL be ignored; at most one transaction is outstanding.
REQ-021 data_wr SHALL be 1 for stores; data_size SHALL equal latched ex_size.
REQ-022 data_wdata SHALL replicate the low 8/16/32 bits of store data across the bus for byte/half/word stores, and pass it unchanged for dword.
REQ-023 data_wstrb SHALL be 1, 3, 0xF or all-ones for byte, half, word or dword respectively, shifted left by lane = addr[log2(LANES)-1:0]; for loads it SHALL be 0.
REQ-024 resp_rdata SHALL be data_rdata shifted right by lane*8 and sign-extended (ex_unsigned=0) or zero-extended from the access size; for stores it SHALL be 0.
REQ-025 Flush in REQ SHALL keep data_req asserted until data_addr_ok (no request withdrawal), then go to DRAIN.
REQ-026 Flush in WAIT_DATA SHALL go to DRAIN; flush in EXC SHALL go to IDLE with no resp_valid.
REQ-027 DRAIN SHALL go to IDLE on data_data_ok with no resp_valid.
REQ-028 A flushed access SHALL never produce resp_valid; flush in IDLE SHALL block acceptance.
REQ-029 mem_stall SHALL be 1 in REQ, WAIT_DATA, DRAIN and EXC, and 0 in IDLE.

Reset
REQ-030 On cpu_rst_n=0, asynchronously: state=IDLE, data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0, data_wstrb=0, resp_valid=0, resp_rdata=0, resp_exc=00, badvaddr=0, mem_stall=0.
REQ-031 Reset mid-transaction SHALL abandon the transaction; a late data_data_ok after reset release in IDLE SHALL be ignored.

Verification
REQ-032 Check: lw addr 0x1000, addr_ok after 2 cycles, data_ok 3 cycles later with rdata 0x8899AABB -> one resp_valid pulse, resp_rdata=0x8899AABB, mem_stall high throughout.
REQ-033 Check: lb addr 0x1003, rdata 0x80112233 -> resp_rdata=0xFFFFFF80; the same access as lbu -> 0x00000080.
REQ-034 Check: sh addr 0x2002, wdata 0x0000BEEF -> data_wstrb=0xC, data_wdata=0xBEEFBEEF, data_size=1, data_wr=1.
REQ-035 Check: lw addr 0x3001 -> no data_req, resp_exc=01, badvaddr=0x3001; sw addr 0x3002 -> resp_exc=10.
REQ-036 Check: flush asserted while in REQ (addr_ok low) -> data_req held until addr_ok, DRAIN until data_ok, no resp_valid, then ex_ready=1.
REQ-037 Check: with DATA_W=64, ld addr 0x4004 -> resp_exc=01; lw addr 0x4004 -> data_wstrb=0, and resp_rdata = data_rdata[63:32] sign-extended.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store unit between the execute stage and a split-handshake data bus.
//   One access is in flight at a time. Misaligned accesses never reach the bus
//   and instead complete with an address-error response. A flush cancels the
//   response of the current access, but a request already on the bus is never
//   withdrawn.
//
// Ports
//   cpu_clk_50M, cpu_rst_n     clock, asynchronous active-low reset
//   ex_valid/ex_load/ex_store  access request and type from execute
//   ex_size, ex_unsigned       0=byte 1=half 2=word 3=dword; zero-extend load
//   ex_addr, ex_wdata          effective address, LSB-aligned store data
//   ex_ready                   unit is idle and can accept a request
//   flush                      exception flush from the pipeline
//   data_req/wr/size/addr      bus address phase (held until data_addr_ok)
//   data_wdata, data_wstrb     lane-replicated store data and byte strobes
//   data_addr_ok, data_data_ok address accepted / data phase complete
//   data_rdata                 raw bus read data
//   resp_valid, resp_rdata     single-cycle completion pulse, formatted load data
//   resp_exc, badvaddr         00 none, 01 ADEL, 10 ADES; faulting address
//   mem_stall                  hold the pipeline while an access is in flight
//   fsm_state                  current FSM state, for observation
//
// Handshake: an access is accepted on a rising edge where ex_valid, a type bit
// and ex_ready are high and flush is low. A bus request is accepted on the
// edge where data_req and data_addr_ok are both high; its data phase completes
// on a later edge where data_data_ok is high.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  cpu_clk_50M,
    input  logic                  cpu_rst_n,
    input  logic                  ex_valid,
    input  logic                  ex_load,
    input  logic                  ex_store,
    input  logic [1:0]            ex_size,
    input  logic                  ex_unsigned,
    input  logic [ADDR_W-1:0]     ex_addr,
    input  logic [DATA_W-1:0]     ex_wdata,
    output logic                  ex_ready,
    input  logic                  flush,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [ADDR_W-1:0]     data_addr,
    output logic [DATA_W-1:0]     data_wdata,
    output logic [DATA_W/8-1:0]   data_wstrb,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [DATA_W-1:0]     data_rdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic [1:0]            resp_exc,
    output logic [ADDR_W-1:0]     badvaddr,
    output logic                  mem_stall,
    output logic [2:0]            fsm_state
);

    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT_DATA = 3'd2,
        DRAIN     = 3'd3,
        EXC       = 3'd4
    } state_t;

    state_t              state;
    logic                lat_load;
    logic                lat_unsigned;
    logic [1:0]          lat_size;
    logic [LANE_W-1:0]   lat_lane;
    logic [ADDR_W-1:0]   lat_addr;
    logic                flushed;   // flush seen while the request is still on the bus

    logic                accept;
    logic                misaligned;

    // Copy the low 1/2/4 bytes of store data into every lane so the slave can
    // pick whichever lanes the strobe enables.
    function automatic logic [DATA_W-1:0] replicate_store(input logic [DATA_W-1:0] w,
                                                          input logic [1:0]        size);
        logic [DATA_W-1:0] r;
        r = w;
        for (int i = 0; i < LANES; i++) begin
            case (size)
                2'd0:    r[i*8 +: 8] = w[7:0];
                2'd1:    r[i*8 +: 8] = w[(i%2)*8 +: 8];
                2'd2:    r[i*8 +: 8] = w[(i%4)*8 +: 8];
                default: r[i*8 +: 8] = w[i*8 +: 8];
            endcase
        end
        return r;
    endfunction

    function automatic logic [LANES-1:0] store_strobe(input logic [1:0]        size,
                                                      input logic [LANE_W-1:0] lane);
        logic [LANES-1:0] base;
        case (size)
            2'd0:    base = LANES'(1);
            2'd1:    base = LANES'(3);
            2'd2:    base = LANES'(4'hF);
            default: base = '1;
        endcase
        return base << lane;
    endfunction

    // Move the addressed bytes down to bit 0, then sign- or zero-extend from
    // the access width.
    function automatic logic [DATA_W-1:0] format_load(input logic [DATA_W-1:0] rd,
                                                      input logic [LANE_W-1:0] lane,
                                                      input logic [1:0]        size,
                                                      input logic              uns);
        logic [DATA_W-1:0] shifted;
        logic [DATA_W-1:0] r;
        logic              ext;
        int                width;
        shifted = rd >> {lane, 3'b000};
        case (size)
            2'd0:    begin width = 8;      ext = shifted[7];        end
            2'd1:    begin width = 16;     ext = shifted[15];       end
            2'd2:    begin width = 32;     ext = shifted[31];       end
            default: begin width = DATA_W; ext = shifted[DATA_W-1]; end
        endcase
        ext = ext & ~uns;
        r = shifted;
        for (int b = 0; b < DATA_W; b++) begin
            if (b >= width) r[b] = ext;
        end
        return r;
    endfunction

    always_comb begin
        case (ex_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = ex_addr[0];
            2'd2:    misaligned = |ex_addr[1:0];
            // A dword cannot be carried on a 32-bit bus at all.
            default: misaligned = (DATA_W == 32) || (|ex_addr[2:0]);
        endcase
    end

    assign ex_ready  = (state == IDLE);
    assign mem_stall = (state != IDLE);
    assign fsm_state = state;
    assign accept    = ex_valid & (ex_load | ex_store) & ex_ready & ~flush;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state        <= IDLE;
            lat_load     <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_size     <= 2'd0;
            lat_lane     <= '0;
            lat_addr     <= '0;
            flushed      <= 1'b0;
            data_req     <= 1'b0;
            data_wr      <= 1'b0;
            data_size    <= 2'd0;
            data_addr    <= '0;
            data_wdata   <= '0;
            data_wstrb   <= '0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_exc     <= 2'b00;
            badvaddr     <= '0;
        end else begin
            // Response outputs are pulses unless a completion sets them below.
            resp_valid <= 1'b0;
            resp_exc   <= 2'b00;

            case (state)
                IDLE: begin
                    if (accept) begin
                        // A type conflict (both bits set) is treated as a load.
                        lat_load     <= ex_load;
                        lat_unsigned <= ex_unsigned;
                        lat_size     <= ex_size;
                        lat_lane     <= ex_addr[LANE_W-1:0];
                        lat_addr     <= ex_addr;
                        flushed      <= 1'b0;
                        if (misaligned) begin
                            state <= EXC;
                        end else begin
                            state      <= REQ;
                            data_req   <= 1'b1;
                            data_wr    <= ~ex_load;
                            data_size  <= ex_size;
                            data_addr  <= ex_addr;
                            data_wdata <= ex_load ? '0 : replicate_store(ex_wdata, ex_size);
                            data_wstrb <= ex_load ? '0 : store_strobe(ex_size, ex_addr[LANE_W-1:0]);
                        end
                    end
                end

                REQ: begin
                    // The request stays on the bus even when flushed; the flush
                    // only redirects where the data phase goes.
                    if (flush) flushed <= 1'b1;
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        state    <= (flushed || flush) ? DRAIN : WAIT_DATA;
                    end
                end

                WAIT_DATA: begin
                    if (data_data_ok) begin
                        state <= IDLE;
                        if (!flush) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= lat_load
                                        ? format_load(data_rdata, lat_lane, lat_size, lat_unsigned)
                                        : '0;
                        end
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (data_data_ok) state <= IDLE;
                end

                EXC: begin
                    state <= IDLE;
                    if (!flush) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_exc   <= lat_load ? 2'b01 : 2'b10;
                        badvaddr   <= lat_addr;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit. Two instances share the stimulus: a 32-bit
// bus unit and a 64-bit bus unit, each with its own ex_valid so only the
// selected one takes an access. Expected results come from arithmetic models
// of the load/store formatting rules and from the cycle timeline of the
// bus handshake.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        v32, v64;
    logic        ex_load, ex_store, ex_unsigned, flush;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr;
    logic [63:0] ex_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [63:0] data_rdata;

    logic        d32_ready, d32_req, d32_wr, d32_resp_valid, d32_stall;
    logic [1:0]  d32_size, d32_exc;
    logic [31:0] d32_addr, d32_wdata, d32_rdata, d32_badv;
    logic [3:0]  d32_wstrb;
    logic [2:0]  d32_state;

    logic        d64_ready, d64_req, d64_wr, d64_resp_valid, d64_stall;
    logic [1:0]  d64_size, d64_exc;
    logic [31:0] d64_addr, d64_badv;
    logic [63:0] d64_wdata, d64_rdata;
    logic [7:0]  d64_wstrb;
    logic [2:0]  d64_state;

    int checks   = 0;
    int failures = 0;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut32 (
        .cpu_clk_50M(clk), .cpu_rst_n(rst_n),
        .ex_valid(v32), .ex_load(ex_load), .ex_store(ex_store), .ex_size(ex_size),
        .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_wdata(ex_wdata[31:0]),
        .ex_ready(d32_ready), .flush(flush),
        .data_req(d32_req), .data_wr(d32_wr), .data_size(d32_size), .data_addr(d32_addr),
        .data_wdata(d32_wdata), .data_wstrb(d32_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata[31:0]),
        .resp_valid(d32_resp_valid), .resp_rdata(d32_rdata), .resp_exc(d32_exc),
        .badvaddr(d32_badv), .mem_stall(d32_stall), .fsm_state(d32_state)
    );

    mem_access_unit #(.ADDR_W(32), .DATA_W(64)) dut64 (
        .cpu_clk_50M(clk), .cpu_rst_n(rst_n),
        .ex_valid(v64), .ex_load(ex_load), .ex_store(ex_store), .ex_size(ex_size),
        .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_ready(d64_ready), .flush(flush),
        .data_req(d64_req), .data_wr(d64_wr), .data_size(d64_size), .data_addr(d64_addr),
        .data_wdata(d64_wdata), .data_wstrb(d64_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .resp_valid(d64_resp_valid), .resp_rdata(d64_rdata), .resp_exc(d64_exc),
        .badvaddr(d64_badv), .mem_stall(d64_stall), .fsm_state(d64_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- observation of the selected instance ----------------
    bit          sel64;
    logic        o_ready, o_req, o_wr, o_resp, o_stall;
    logic [1:0]  o_size, o_exc;
    logic [31:0] o_addr, o_badv;
    logic [63:0] o_wdata, o_rdata;
    logic [7:0]  o_wstrb;

    always_comb begin
        o_ready = sel64 ? d64_ready      : d32_ready;
        o_req   = sel64 ? d64_req        : d32_req;
        o_wr    = sel64 ? d64_wr         : d32_wr;
        o_resp  = sel64 ? d64_resp_valid : d32_resp_valid;
        o_stall = sel64 ? d64_stall      : d32_stall;
        o_size  = sel64 ? d64_size       : d32_size;
        o_exc   = sel64 ? d64_exc        : d32_exc;
        o_addr  = sel64 ? d64_addr       : d32_addr;
        o_badv  = sel64 ? d64_badv       : d32_badv;
        o_wdata = sel64 ? d64_wdata      : {32'd0, d32_wdata};
        o_rdata = sel64 ? d64_rdata      : {32'd0, d32_rdata};
        o_wstrb = sel64 ? d64_wstrb      : {4'd0, d32_wstrb};
    end

    // ---------------- reference model ----------------
    function automatic bit exp_misaligned(input logic [31:0] addr, input logic [1:0] sz, input bit w64);
        int align;
        align = 1 << sz;
        return ((addr % align) != 0) || (sz == 2'd3 && !w64);
    endfunction

    function automatic logic [63:0] exp_load(input logic [63:0] rd, input logic [31:0] addr,
                                             input logic [1:0] sz, input bit uns, input bit w64);
        int          lanes, bits;
        logic [63:0] v, m;
        lanes = w64 ? 8 : 4;
        bits  = 8 << sz;
        v = w64 ? rd : (rd & 64'hFFFF_FFFF);
        v = v >> (8 * (addr % lanes));
        if (bits < 64) begin
            m = (64'd1 << bits) - 1;
            v = v & m;
            if (!uns && v[bits-1]) v = v | ~m;
        end
        if (!w64) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    function automatic logic [7:0] exp_wstrb(input logic [31:0] addr, input logic [1:0] sz, input bit w64);
        int lanes, nbytes;
        lanes  = w64 ? 8 : 4;
        nbytes = 1 << sz;
        return 8'(((1 << nbytes) - 1) << (addr % lanes));
    endfunction

    function automatic logic [63:0] exp_wdata(input logic [63:0] wd, input logic [1:0] sz, input bit w64);
        int          bits, dw;
        logic [63:0] m, r;
        bits = 8 << sz;
        dw   = w64 ? 64 : 32;
        m = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 1);
        r = 64'd0;
        for (int k = 0; k < dw / bits; k++) r = r | ((wd & m) << (k * bits));
        return r;
    endfunction

    // ---------------- driver ----------------
    // Observation record of the last access; bit c of each mask is the signal
    // value in cycle c after the accepting edge.
    logic [63:0] obs_req_mask, obs_stall_mask, obs_resp_mask;
    logic [63:0] obs_rdata, obs_wdata;
    logic [31:0] obs_addr, obs_badv;
    logic [7:0]  obs_wstrb;
    logic [1:0]  obs_exc, obs_size;
    logic        obs_wr, obs_unstable, obs_ready_end;

    // Presents one access, answers the bus with data_addr_ok in cycle aw and
    // data_data_ok in cycle aw+dw, and pulses flush in cycle flush_at (-1: none).
    task automatic run_access(input bit w64, input bit ld, input logic [1:0] sz, input bit uns,
                              input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                              input int aw, input int dw, input int flush_at);
        bit mis;
        int last;
        mis  = exp_misaligned(addr, sz, w64);
        last = mis ? 0 : aw + dw;
        sel64 = w64;
        ex_load = ld; ex_store = !ld; ex_size = sz; ex_unsigned = uns;
        ex_addr = addr; ex_wdata = wd;
        if (w64) v64 = 1'b1; else v32 = 1'b1;
        step();
        v32 = 1'b0; v64 = 1'b0;
        obs_req_mask = '0; obs_stall_mask = '0; obs_resp_mask = '0;
        obs_rdata = '0; obs_wdata = '0; obs_addr = '0; obs_badv = '0;
        obs_wstrb = '0; obs_exc = '0; obs_size = '0; obs_wr = 1'b0; obs_unstable = 1'b0;
        for (int c = 0; c <= last + 3; c++) begin
            if (o_req) begin
                if (obs_req_mask == 64'd0) begin
                    obs_addr = o_addr; obs_wr = o_wr; obs_size = o_size;
                    obs_wdata = o_wdata; obs_wstrb = o_wstrb;
                end else if (o_addr !== obs_addr || o_wr !== obs_wr || o_size !== obs_size ||
                             o_wdata !== obs_wdata || o_wstrb !== obs_wstrb) begin
                    obs_unstable = 1'b1;
                end
                obs_req_mask[c] = 1'b1;
            end
            if (o_stall) obs_stall_mask[c] = 1'b1;
            if (o_resp) begin
                obs_resp_mask[c] = 1'b1;
                obs_rdata = o_rdata; obs_exc = o_exc; obs_badv = o_badv;
            end
            data_addr_ok = !mis && (c == aw);
            data_data_ok = !mis && (c == aw + dw);
            data_rdata   = (c == aw + dw) ? rd : {$urandom, $urandom};
            flush        = (c == flush_at);
            step();
        end
        data_addr_ok = 1'b0; data_data_ok = 1'b0; flush = 1'b0;
        obs_ready_end = o_ready;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if ({d32_req, d32_wr, d32_resp_valid, d32_stall, d32_exc, d32_wstrb} !== 10'd0) begin
            failures++; $display("FAIL reset32_ctrl got=%b exp=0", {d32_req, d32_wr, d32_resp_valid, d32_stall, d32_exc, d32_wstrb}); end
        checks++; if ({d32_addr, d32_wdata, d32_rdata, d32_badv, d32_size} !== 130'd0) begin
            failures++; $display("FAIL reset32_data got=%h exp=0", {d32_addr, d32_wdata, d32_rdata, d32_badv, d32_size}); end
        checks++; if ({d64_req, d64_resp_valid, d64_stall, d64_wstrb, d64_wdata, d64_rdata} !== 139'd0) begin
            failures++; $display("FAIL reset64 got=%h exp=0", {d64_req, d64_resp_valid, d64_stall, d64_wstrb, d64_wdata, d64_rdata}); end
        checks++; if (d32_ready !== 1'b1 || d64_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b%b exp=11", d32_ready, d64_ready); end
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_lw();
        run_access(1'b0, 1'b1, 2'd2, 1'b0, 32'h1000, 64'd0, 64'h8899AABB, 2, 3, -1);
        checks++; if (obs_resp_mask !== 64'h40) begin failures++; $display("FAIL lw_resp_mask got=%h exp=40", obs_resp_mask); end
        checks++; if (obs_rdata !== 64'h8899AABB) begin failures++; $display("FAIL lw_rdata got=%h exp=8899aabb", obs_rdata); end
        checks++; if (obs_stall_mask !== 64'h3F) begin failures++; $display("FAIL lw_stall got=%h exp=3f", obs_stall_mask); end
        checks++; if (obs_req_mask !== 64'h7) begin failures++; $display("FAIL lw_req got=%h exp=7", obs_req_mask); end
        checks++; if ({obs_addr, obs_size, obs_wr, obs_wstrb, obs_exc} !== {32'h1000, 2'd2, 1'b0, 8'h0, 2'b00}) begin
            failures++; $display("FAIL lw_bus got=%h/%0d/%b/%h/%b", obs_addr, obs_size, obs_wr, obs_wstrb, obs_exc); end
    endtask

    task automatic test_lb_sign();
        run_access(1'b0, 1'b1, 2'd0, 1'b0, 32'h1003, 64'd0, 64'h80112233, 1, 1, -1);
        checks++; if (obs_rdata !== 64'hFFFFFF80) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffff80", obs_rdata); end
        run_access(1'b0, 1'b1, 2'd0, 1'b1, 32'h1003, 64'd0, 64'h80112233, 1, 1, -1);
        checks++; if (obs_rdata !== 64'h00000080) begin failures++; $display("FAIL lbu_rdata got=%h exp=00000080", obs_rdata); end
        checks++; if (obs_resp_mask !== 64'h8) begin failures++; $display("FAIL lbu_resp_mask got=%h exp=8", obs_resp_mask); end
    endtask

    task automatic test_sh();
        run_access(1'b0, 1'b0, 2'd1, 1'b0, 32'h2002, 64'h0000BEEF, 64'hDEAD, 0, 2, -1);
        checks++; if (obs_wstrb !== 8'hC) begin failures++; $display("FAIL sh_wstrb got=%h exp=c", obs_wstrb); end
        checks++; if (obs_wdata !== 64'hBEEFBEEF) begin failures++; $display("FAIL sh_wdata got=%h exp=beefbeef", obs_wdata); end
        checks++; if (obs_size !== 2'd1 || obs_wr !== 1'b1) begin failures++; $display("FAIL sh_size_wr got=%0d/%b exp=1/1", obs_size, obs_wr); end
        checks++; if (obs_rdata !== 64'd0 || obs_resp_mask !== 64'h8) begin
            failures++; $display("FAIL sh_resp got=%h/%h exp=0/8", obs_rdata, obs_resp_mask); end
    endtask

    task automatic test_misaligned();
        run_access(1'b0, 1'b1, 2'd2, 1'b0, 32'h3001, 64'd0, 64'd0, 0, 1, -1);
        checks++; if (obs_req_mask !== 64'd0) begin failures++; $display("FAIL adel_req got=%h exp=0", obs_req_mask); end
        checks++; if (obs_resp_mask !== 64'h2 || obs_exc !== 2'b01) begin failures++; $display("FAIL adel_resp got=%h/%b exp=2/01", obs_resp_mask, obs_exc); end
        checks++; if (obs_badv !== 32'h3001) begin failures++; $display("FAIL adel_badv got=%h exp=3001", obs_badv); end
        checks++; if (obs_stall_mask !== 64'h1) begin failures++; $display("FAIL adel_stall got=%h exp=1", obs_stall_mask); end
        run_access(1'b0, 1'b0, 2'd2, 1'b0, 32'h3002, 64'h1234, 64'd0, 0, 1, -1);
        checks++; if (obs_exc !== 2'b10 || obs_badv !== 32'h3002) begin failures++; $display("FAIL ades got=%b/%h exp=10/3002", obs_exc, obs_badv); end
        checks++; if (o_exc !== 2'b00) begin failures++; $display("FAIL exc_clears got=%b exp=00", o_exc); end
    endtask

    task automatic test_flush_req();
        run_access(1'b0, 1'b1, 2'd2, 1'b0, 32'h5000, 64'd0, 64'h1111, 3, 2, 0);
        checks++; if (obs_req_mask !== 64'hF) begin failures++; $display("FAIL flreq_req got=%h exp=f", obs_req_mask); end
        checks++; if (obs_resp_mask !== 64'd0) begin failures++; $display("FAIL flreq_resp got=%h exp=0", obs_resp_mask); end
        checks++; if (obs_stall_mask !== 64'h3F) begin failures++; $display("FAIL flreq_stall got=%h exp=3f", obs_stall_mask); end
        checks++; if (obs_ready_end !== 1'b1) begin failures++; $display("FAIL flreq_ready got=%b exp=1", obs_ready_end); end
    endtask

    task automatic test_flush_wait_exc();
        run_access(1'b1, 1'b1, 2'd1, 1'b0, 32'h6006, 64'd0, 64'h7777, 1, 3, 2);
        checks++; if (obs_resp_mask !== 64'd0 || obs_stall_mask !== 64'h1F) begin
            failures++; $display("FAIL flwait got=%h/%h exp=0/1f", obs_resp_mask, obs_stall_mask); end
        run_access(1'b0, 1'b0, 2'd2, 1'b0, 32'h6001, 64'd0, 64'd0, 0, 1, 0);
        checks++; if (obs_resp_mask !== 64'd0 || obs_stall_mask !== 64'h1 || obs_ready_end !== 1'b1) begin
            failures++; $display("FAIL flexc got=%h/%h/%b exp=0/1/1", obs_resp_mask, obs_stall_mask, obs_ready_end); end
    endtask

    task automatic test_flush_idle();
        sel64 = 1'b0;
        ex_load = 1'b1; ex_store = 1'b0; ex_size = 2'd2; ex_addr = 32'h7000;
        v32 = 1'b1; flush = 1'b1;
        step(); step();
        v32 = 1'b0; flush = 1'b0;
        checks++; if (d32_req !== 1'b0 || d32_stall !== 1'b0 || d32_ready !== 1'b1) begin
            failures++; $display("FAIL flidle got=%b%b%b exp=001", d32_req, d32_stall, d32_ready); end
        step();
    endtask

    task automatic test_dw64();
        run_access(1'b1, 1'b1, 2'd3, 1'b0, 32'h4004, 64'd0, 64'd0, 0, 1, -1);
        checks++; if (obs_exc !== 2'b01 || obs_req_mask !== 64'd0) begin failures++; $display("FAIL ld64_exc got=%b/%h exp=01/0", obs_exc, obs_req_mask); end
        run_access(1'b1, 1'b1, 2'd2, 1'b0, 32'h4004, 64'd0, 64'h81234567_00001111, 1, 2, -1);
        checks++; if (obs_wstrb !== 8'h0 || obs_req_mask !== 64'h3) begin failures++; $display("FAIL lw64_bus got=%h/%h exp=0/3", obs_wstrb, obs_req_mask); end
        checks++; if (obs_rdata !== 64'hFFFFFFFF_81234567) begin failures++; $display("FAIL lw64_rdata got=%h exp=ffffffff81234567", obs_rdata); end
        run_access(1'b0, 1'b1, 2'd3, 1'b0, 32'h4000, 64'd0, 64'd0, 0, 1, -1);
        checks++; if (obs_exc !== 2'b01) begin failures++; $display("FAIL ld32_exc got=%b exp=01", obs_exc); end
    endtask

    task automatic test_reset_mid();
        sel64 = 1'b0;
        ex_load = 1'b1; ex_store = 1'b0; ex_size = 2'd2; ex_addr = 32'h8000;
        v32 = 1'b1; step(); v32 = 1'b0;
        data_addr_ok = 1'b1; step(); data_addr_ok = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (d32_stall !== 1'b0 || d32_req !== 1'b0 || d32_ready !== 1'b1) begin
            failures++; $display("FAIL rstmid_async got=%b%b%b exp=001", d32_stall, d32_req, d32_ready); end
        step(); rst_n = 1'b1; step();
        data_data_ok = 1'b1; data_rdata = 64'h1234; step(); data_data_ok = 1'b0;
        checks++; if (d32_resp_valid !== 1'b0 || d32_stall !== 1'b0) begin
            failures++; $display("FAIL rstmid_late got=%b%b exp=00", d32_resp_valid, d32_stall); end
        step();
    endtask

    task automatic test_random();
        bit          w64, ld, uns, mis, fl;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [63:0] wd, rd, e_resp, e_stall, e_req, e_wd;
        int          aw, dw, fa, busy;
        for (int n = 0; n < 60; n++) begin
            w64 = 1'($urandom_range(0, 1)); ld = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 1);
            wd = {$urandom, $urandom}; rd = {$urandom, $urandom};
            aw = $urandom_range(0, 4); dw = $urandom_range(1, 4);
            fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
            mis  = exp_misaligned(addr, sz, w64);
            busy = mis ? 0 : aw + dw;
            fl   = (fa >= 0) && (fa <= busy);
            e_resp  = fl ? 64'd0 : (64'd1 << (busy + 1));
            e_stall = (64'd1 << (busy + 1)) - 1;
            e_req   = mis ? 64'd0 : ((64'd1 << (aw + 1)) - 1);
            run_access(w64, ld, sz, uns, addr, wd, rd, aw, dw, fa);
            checks++; if (obs_resp_mask !== e_resp) begin failures++; $display("FAIL rnd%0d_resp got=%h exp=%h", n, obs_resp_mask, e_resp); end
            checks++; if (obs_stall_mask !== e_stall) begin failures++; $display("FAIL rnd%0d_stall got=%h exp=%h", n, obs_stall_mask, e_stall); end
            checks++; if (obs_req_mask !== e_req) begin failures++; $display("FAIL rnd%0d_req got=%h exp=%h", n, obs_req_mask, e_req); end
            checks++; if (obs_ready_end !== 1'b1) begin failures++; $display("FAIL rnd%0d_ready got=%b exp=1", n, obs_ready_end); end
            if (mis) begin
                if (!fl) begin
                    checks++; if (obs_exc !== (ld ? 2'b01 : 2'b10) || obs_badv !== addr) begin
                        failures++; $display("FAIL rnd%0d_exc got=%b/%h exp=%b/%h", n, obs_exc, obs_badv, ld ? 2'b01 : 2'b10, addr); end
                end
            end else begin
                checks++; if (obs_addr !== addr || obs_size !== sz || obs_wr !== !ld || obs_unstable !== 1'b0) begin
                    failures++; $display("FAIL rnd%0d_bus got=%h/%0d/%b/%b exp=%h/%0d/%b/0", n, obs_addr, obs_size, obs_wr, obs_unstable, addr, sz, !ld); end
                checks++; if (obs_wstrb !== (ld ? 8'h0 : exp_wstrb(addr, sz, w64))) begin
                    failures++; $display("FAIL rnd%0d_wstrb got=%h exp=%h", n, obs_wstrb, ld ? 8'h0 : exp_wstrb(addr, sz, w64)); end
                if (!ld) begin
                    e_wd = exp_wdata(wd, sz, w64);
                    checks++; if (obs_wdata !== e_wd) begin failures++; $display("FAIL rnd%0d_wdata got=%h exp=%h", n, obs_wdata, e_wd); end
                end
                if (!fl) begin
                    checks++; if (obs_rdata !== (ld ? exp_load(rd, addr, sz, uns, w64) : 64'd0) || obs_exc !== 2'b00) begin
                        failures++; $display("FAIL rnd%0d_rdata got=%h/%b exp=%h/00", n, obs_rdata, obs_exc, ld ? exp_load(rd, addr, sz, uns, w64) : 64'd0); end
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0; v32 = 1'b0; v64 = 1'b0; sel64 = 1'b0;
        ex_load = 1'b0; ex_store = 1'b0; ex_size = 2'd0; ex_unsigned = 1'b0;
        ex_addr = '0; ex_wdata = '0; flush = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        test_reset();
        test_lw();
        test_lb_sign();
        test_sh();
        test_misaligned();
        test_flush_req();
        test_flush_wait_exc();
        test_flush_idle();
        test_dw64();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
